// File: rtl/motoro3_line_monitor.sv
// motoro3_line_monitor: decodes the six bridge gate lines back into the commutation step
// and reports step period, rotation direction, skipped steps and shoot-through.
module motoro3_line_monitor #(
    parameter int STABLE_CYC = 16,
    parameter int PERIOD_W   = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mAHp,
    input  logic                mALp,
    input  logic                mBHp,
    input  logic                mBLp,
    input  logic                mCHp,
    input  logic                mCLp,
    input  logic [11:0]         holdLen,
    input  logic                faultClr,
    output logic [3:0]          monStep,
    output logic                monValid,
    output logic                monDir,
    output logic [PERIOD_W-1:0] monPeriod,
    output logic                monPeriodVld,
    output logic                monSkip,
    output logic                monShoot
);
    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

    logic [5:0]          r_s1, r_s2;
    logic [11:0]         r_hold [3];
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_prev;
    logic [PERIOD_W-1:0] r_per;
    logic [2:0]          w_hp, w_lp, w_h, w_l;
    logic [5:0]          w_pat;
    logic [3:0]          w_raw, w_fwd, w_rev;
    logic [CW-1:0]       w_cnt;
    logic                w_accept, w_both_valid, w_shoot;

    // index 2 = phase A, 1 = phase B, 0 = phase C
    assign w_hp = {r_s2[5], r_s2[3], r_s2[1]};
    assign w_lp = {r_s2[4], r_s2[2], r_s2[0]};
    assign w_shoot = |(w_hp & w_lp);

    always_comb begin
        w_h = '0;
        w_l = '0;
        for (int i = 0; i < 3; i++) begin
            w_h[i] = w_hp[i] | (r_hold[i] != 12'd0);
            w_l[i] = ~w_h[i] & w_lp[i];
        end
    end

    assign w_pat = {w_h[2], w_l[2], w_h[1], w_l[1], w_h[0], w_l[0]};

    always_comb begin
        w_raw = 4'hF;
        case (w_pat)
            6'b10_01_00: w_raw = 4'd0;
            6'b10_00_01: w_raw = 4'd1;
            6'b00_10_01: w_raw = 4'd2;
            6'b01_10_00: w_raw = 4'd3;
            6'b01_00_10: w_raw = 4'd4;
            6'b00_01_10: w_raw = 4'd5;
            default:     w_raw = 4'hF;
        endcase
    end

    // a fresh raw value counts as cycle 0 of its stability window
    assign w_cnt        = (w_raw != r_prev) ? '0 : r_cnt;
    assign w_accept     = (w_raw != monStep) && (w_cnt == CW'(STABLE_CYC - 1));
    assign w_fwd        = (monStep == 4'd5) ? 4'd0 : monStep + 4'd1;
    assign w_rev        = (monStep == 4'd0) ? 4'd5 : monStep - 4'd1;
    assign w_both_valid = monValid && (w_raw != 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1         <= '0;
            r_s2         <= '0;
            for (int i = 0; i < 3; i++) r_hold[i] <= '0;
            r_cnt        <= '0;
            r_prev       <= 4'hF;
            r_per        <= '0;
            monStep      <= 4'hF;
            monValid     <= 1'b0;
            monDir       <= 1'b0;
            monPeriod    <= '0;
            monPeriodVld <= 1'b0;
            monSkip      <= 1'b0;
            monShoot     <= 1'b0;
        end else begin
            r_s1   <= {mAHp, mALp, mBHp, mBLp, mCHp, mCLp};
            r_s2   <= r_s1;
            r_prev <= w_raw;
            for (int i = 0; i < 3; i++)
                r_hold[i] <= w_hp[i] ? holdLen : (r_hold[i] != 12'd0 ? r_hold[i] - 12'd1 : 12'd0);
            r_cnt        <= (w_raw == monStep || w_accept) ? '0 : w_cnt + 1'b1;
            r_per        <= w_accept ? '0 : (&r_per ? r_per : r_per + 1'b1);
            monPeriodVld <= w_accept && w_both_valid;
            monSkip      <= w_accept && w_both_valid && (w_raw != w_fwd) && (w_raw != w_rev);
            monShoot     <= w_shoot | (monShoot & ~faultClr);
            if (w_accept) begin
                monStep  <= w_raw;
                monValid <= (w_raw != 4'hF);
            end
            if (w_accept && w_both_valid) begin
                monPeriod <= &r_per ? r_per : r_per + 1'b1;
                if (w_raw == w_fwd)
                    monDir <= 1'b1;
                else if (w_raw == w_rev)
                    monDir <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_motoro3_line_monitor.sv
// tb_motoro3_line_monitor: scoreboard bench; expected step changes are queued as gate
// patterns are driven and popped when monStep changes.
`timescale 1ns/1ps
module tb_motoro3_line_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mAHp = 0, mALp = 0, mBHp = 0, mBLp = 0, mCHp = 0, mCLp = 0;
    logic [11:0] holdLen = '0;
    logic        faultClr = 1'b0;
    logic [3:0]  monStep;
    logic        monValid, monDir, monPeriodVld, monSkip, monShoot;
    logic [24:0] monPeriod;

    motoro3_line_monitor dut (
        .clk(clk), .rst(rst),
        .mAHp(mAHp), .mALp(mALp), .mBHp(mBHp), .mBLp(mBLp), .mCHp(mCHp), .mCLp(mCLp),
        .holdLen(holdLen), .faultClr(faultClr),
        .monStep(monStep), .monValid(monValid), .monDir(monDir),
        .monPeriod(monPeriod), .monPeriodVld(monPeriodVld),
        .monSkip(monSkip), .monShoot(monShoot)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] step;
        logic       dir;
        logic       skip;
        logic       pvld;
        int         per;
        int         at;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0, n_pass = 0;
    logic [3:0] m_step = 4'hF;
    logic       m_dir = 1'b0;
    int         m_last = 0;
    logic [3:0] last_step = 4'hF;
    bit         g_auto = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // gate pattern {AH,AL,BH,BL,CH,CL}; 6 is an illegal two-high pattern
    function automatic logic [5:0] pat(input int s);
        case (s)
            0: return 6'b10_01_00;
            1: return 6'b10_00_01;
            2: return 6'b00_10_01;
            3: return 6'b01_10_00;
            4: return 6'b01_00_10;
            5: return 6'b00_01_10;
            6: return 6'b10_10_00;
            default: return 6'b00_00_00;
        endcase
    endfunction

    task automatic expect_step(input logic [3:0] s, input int at);
        exp_t e;
        bit   fwd, rev;
        e.step = s; e.at = at; e.skip = 0; e.pvld = 0; e.per = 0;
        if (s != 4'hF && m_step != 4'hF) begin
            fwd = ((int'(m_step) + 1) % 6) == int'(s);
            rev = ((int'(m_step) + 5) % 6) == int'(s);
            if (fwd) m_dir = 1'b1;
            else if (rev) m_dir = 1'b0;
            e.skip = !fwd && !rev;
            e.pvld = 1'b1;
            e.per  = at - m_last;
        end
        e.dir  = m_dir;
        m_last = at;
        m_step = s;
        q.push_back(e);
    endtask

    // hold pattern s for n cycles; Hp chopped on/off when off != 0
    task automatic drive(input int s, input int n, input int on, input int off);
        logic [5:0] p;
        logic       hp;
        p = pat(s);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            if (t == 0 && g_auto && s < 6 && s != int'(m_step)) expect_step(4'(s), cyc + 18);
            hp = (off == 0) || ((t % (on + off)) < on);
            {mAHp, mALp, mBHp, mBLp, mCHp, mCLp} = {p[5] & hp, p[4], p[3] & hp, p[2], p[1] & hp, p[0]};
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) last_step = 4'hF;
        else if (monStep !== last_step) begin
            if (q.size() == 0) check("unexpected_step", monStep, last_step);
            else begin
                e = q.pop_front();
                check("step", monStep, e.step);
                check("latency_cycle", cyc, e.at);
                check("valid", monValid, e.step != 4'hF);
                check("dir", monDir, e.dir);
                check("skip", monSkip, e.skip);
                check("period_vld", monPeriodVld, e.pvld);
                if (e.pvld) check("period", monPeriod, e.per);
            end
            last_step = monStep;
        end else if (monPeriodVld || monSkip)
            check("orphan_pulse", {monPeriodVld, monSkip}, 0);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", monStep, 4'hF);
        check("rst_valid", monValid, 0);
        check("rst_dir", monDir, 0);
        check("rst_period", monPeriod, 0);
        check("rst_pvld", monPeriodVld, 0);
        check("rst_skip", monSkip, 0);
        check("rst_shoot", monShoot, 0);
        rst = 1'b0;
        drive(15, 20, 0, 0);
        // forward sweep with 50% PWM; hold window equals off-time
        holdLen = 12'd100;
        for (int k = 0; k < 6; k++) drive(k, 1000, 100, 100);
        drive(0, 1000, 100, 100);
        // PWM bridging: 150 off with 200 hold stays at step 0
        holdLen = 12'd200;
        drive(0, 800, 50, 150);
        // hold shorter than off-time: drop to idle, then back
        holdLen = 12'd100;
        g_auto = 1'b0;
        expect_step(4'hF, cyc + 1 + 168);
        drive(0, 200, 50, 150);
        g_auto = 1'b1;
        holdLen = 12'd0;
        drive(0, 300, 0, 0);
        // reverse then skip
        for (int k = 5; k >= 1; k--) drive(k, 300, 0, 0);
        drive(4, 300, 0, 0);
        // glitch rejection
        drive(6, 10, 0, 0);
        drive(4, 300, 0, 0);
        drive(6, 10, 0, 0);
        drive(5, 300, 0, 0);
        // shoot-through on phase B
        check("shoot_idle", monShoot, 0);
        @(posedge clk); #1 mBHp = 1'b1;
        @(posedge clk); #1 mBHp = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("shoot_set", monShoot, 1);
        repeat (20) @(posedge clk);
        #1 check("shoot_sticky", monShoot, 1);
        @(posedge clk); #1 faultClr = 1'b1;
        @(posedge clk); #1 faultClr = 1'b0;
        check("shoot_clr", monShoot, 0);
        @(posedge clk); #1 mBHp = 1'b1;
        @(posedge clk); #1 mBHp = 1'b0;
        @(posedge clk); #1 faultClr = 1'b1;
        @(posedge clk); #1 faultClr = 1'b0;
        check("shoot_set_wins", monShoot, 1);
        repeat (5) @(posedge clk);
        #1 check("shoot_hold", monShoot, 1);
        // asynchronous reset mid-rotation
        repeat (50) @(posedge clk);
        #10 rst = 1'b1;
        #1;
        check("arst_step", monStep, 4'hF);
        check("arst_valid", monValid, 0);
        check("arst_period", monPeriod, 0);
        check("arst_dir", monDir, 0);
        check("arst_shoot", monShoot, 0);
        m_step = 4'hF;
        m_dir = 1'b0;
        {mAHp, mALp, mBHp, mBLp, mCHp, mCLp} = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_step", monStep, 4'hF);
        check("post_rst_valid", monValid, 0);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
